// File: rtl/multi_channel_data_sync_pkg.sv
// Shared types for the multi-channel handshake synchroniser.
// Holds the per-channel state enum and the channel-id width helper.
package multi_channel_data_sync_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      WAIT_LOW = 2'd2
   } ch_state_e;

   function automatic int ch_id_width(input int n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/data_sync_channel.sv
// One receive channel: valid sync chain, capture register, FSM, ack.
// Ports: clk, reset, async_valid/async_data in; grant in from arbiter;
// pending/ack/data out. Optional parity (MULTI_CHANNEL_DATA_SYNC_PARITY_EN)
// adds async_parity in and parity out.
module data_sync_channel
   import multi_channel_data_sync_pkg::*;
#(
   parameter int STAGE_COUNT = 2,
   parameter int BUS_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 async_valid,
   input  logic [BUS_WIDTH-1:0] async_data,
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   input  logic                 async_parity,
   output logic                 parity,
`endif
   input  logic                 grant,
   output logic                 pending,
   output logic                 ack,
   output logic [BUS_WIDTH-1:0] data
);

   logic [STAGE_COUNT-1:0] sync_q, sync_d;
   ch_state_e              state_q, state_d;
   logic                   ack_q, ack_d;
   logic [BUS_WIDTH-1:0]   data_q, data_d;
   logic                   vsync;

   assign vsync = sync_q[STAGE_COUNT-1];

   always_comb begin
      sync_d  = {sync_q[STAGE_COUNT-2:0], async_valid};
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            // Data is stable while the source holds valid, so it is
            // sampled directly on the edge vsync is first seen high.
            if (vsync) begin
               state_d = PENDING;
               data_d  = async_data;
            end
         end
         PENDING: begin
            if (grant) state_d = vsync ? WAIT_LOW : IDLE;
         end
         WAIT_LOW: begin
            if (!vsync) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Dedicated flop so the ack crossing back is glitch-free.
      ack_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         state_q <= IDLE;
         ack_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (state_q == IDLE && vsync) par_d = async_parity;
   end

   always_ff @(posedge clk) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end

   assign parity = par_q;
`endif

   assign pending = (state_q == PENDING);
   assign ack     = ack_q;
   assign data    = data_q;

endmodule

// File: rtl/multi_channel_data_synchronizer.sv
// Receives CHANNEL_COUNT four-phase async buses and merges them round-robin
// into one registered valid/ready stream tagged with the channel index.
// Ports: clk, reset; asynchronous_data_valid/_data in, _ack out;
// synchronous_data_valid/_data/_channel out, synchronous_data_ready in.
// MULTI_CHANNEL_DATA_SYNC_PARITY_EN adds asynchronous_data_parity in and
// synchronous_parity_error out.
module multi_channel_data_synchronizer
   import multi_channel_data_sync_pkg::*;
#(
   parameter int STAGE_COUNT   = 2,
   parameter int BUS_WIDTH     = 8,
   parameter int CHANNEL_COUNT = 4,
   localparam int CH_W = ch_id_width(CHANNEL_COUNT)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [CHANNEL_COUNT-1:0]           asynchronous_data_valid,
   input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   input  logic [CHANNEL_COUNT-1:0]           asynchronous_data_parity,
   output logic                               synchronous_parity_error,
`endif
   output logic [CHANNEL_COUNT-1:0]           asynchronous_data_ack,
   output logic                               synchronous_data_valid,
   input  logic                               synchronous_data_ready,
   output logic [BUS_WIDTH-1:0]               synchronous_data,
   output logic [CH_W-1:0]                    synchronous_channel
);

   localparam int CW1 = CH_W + 1;

   logic [CHANNEL_COUNT-1:0] pending;
   logic [CHANNEL_COUNT-1:0] grant;
   logic [BUS_WIDTH-1:0]     ch_data [CHANNEL_COUNT];
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   logic [CHANNEL_COUNT-1:0] ch_par;
`endif

   for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
      data_sync_channel #(
         .STAGE_COUNT(STAGE_COUNT),
         .BUS_WIDTH  (BUS_WIDTH)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .async_valid (asynchronous_data_valid[c]),
         .async_data  (asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH]),
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
         .async_parity(asynchronous_data_parity[c]),
         .parity      (ch_par[c]),
`endif
         .grant       (grant[c]),
         .pending     (pending[c]),
         .ack         (asynchronous_data_ack[c]),
         .data        (ch_data[c])
      );
   end

   logic                 valid_q, valid_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic [CH_W-1:0]      chan_q, chan_d;
   logic [CH_W-1:0]      ptr_q, ptr_d;
   logic                 found;
   logic [CH_W-1:0]      gnt_idx;
   logic [CW1-1:0]       scan;
   logic                 load;

   // Scan upward from ptr+1 with wrap; ptr < N and offset <= N keeps the
   // sum below 2N so one conditional subtract does the modulo.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int i = 1; i <= CHANNEL_COUNT; i++) begin
         scan = {1'b0, ptr_q} + CW1'(i);
         if (scan >= CW1'(CHANNEL_COUNT)) scan = scan - CW1'(CHANNEL_COUNT);
         if (!found && pending[scan[CH_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = scan[CH_W-1:0];
         end
      end
   end

   assign load = (!valid_q || synchronous_data_ready) && found;

   always_comb begin
      grant = '0;
      if (load) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      ptr_d   = ptr_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = ch_data[gnt_idx];
         chan_d  = gnt_idx;
         ptr_d   = gnt_idx;
      end else if (synchronous_data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
         ptr_q   <= CH_W'(CHANNEL_COUNT - 1);
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   logic perr_q, perr_d;

   // Odd parity expected: an even total weight flags an error.
   always_comb begin
      perr_d = perr_q;
      if (load) perr_d = ~^{ch_data[gnt_idx], ch_par[gnt_idx]};
   end

   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else       perr_q <= perr_d;
   end

   assign synchronous_parity_error = perr_q;
`endif

   assign synchronous_data_valid = valid_q;
   assign synchronous_data       = data_q;
   assign synchronous_channel    = chan_q;

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Scoreboard bench for multi_channel_data_synchronizer (4 ch, 8 bit, 2 stages).
// Covers parity when MULTI_CHANNEL_DATA_SYNC_PARITY_EN is defined.
module tb_multi_channel_data_synchronizer;

   localparam int SC = 2;
   localparam int BW = 8;
   localparam int CC = 4;
   localparam int CW = 2;

   typedef struct packed {
      logic          perr;
      logic [CW-1:0] ch;
      logic [BW-1:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [CC-1:0]    av = '0;
   logic [CC*BW-1:0] ad = '0;
   logic [CC-1:0]    apar = '0;
   logic [CC-1:0]    ack;
   logic             sv;
   logic             sr = 1'b0;
   logic [BW-1:0]    sd;
   logic [CW-1:0]    sch;
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
   logic             sperr;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   multi_channel_data_synchronizer #(
      .STAGE_COUNT  (SC),
      .BUS_WIDTH    (BW),
      .CHANNEL_COUNT(CC)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .asynchronous_data_valid (av),
      .asynchronous_data       (ad),
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
      .asynchronous_data_parity(apar),
      .synchronous_parity_error(sperr),
`endif
      .asynchronous_data_ack   (ack),
      .synchronous_data_valid  (sv),
      .synchronous_data_ready  (sr),
      .synchronous_data        (sd),
      .synchronous_channel     (sch)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int ch, input logic [BW-1:0] d,
                               input logic p);
      exp_t e;
      e.perr = ~^{d, p};
      e.ch   = CW'(ch);
      e.data = d;
      return e;
   endfunction

   // Accepted words are popped and compared in order.
   always @(negedge clk) begin
      if (!reset && sv && sr) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_word", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("mon_data", sd, e.data);
            check("mon_chan", sch, e.ch);
`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
            check("mon_perr", sperr, e.perr);
`endif
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      av    = '0;
      sb.delete();
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_ack(input int ch, input logic lvl, input string tag);
      int n = 0;
      while (ack[ch] !== lvl && n < 40) begin
         tick(1);
         n++;
      end
      check(tag, ack[ch], lvl);
   endtask

   task automatic send(input int ch, input logic [BW-1:0] d,
                       input logic p, input bit push);
      ad[ch*BW +: BW] = d;
      apar[ch]        = p;
      av[ch]          = 1'b1;
      if (push) sb.push_back(mk(ch, d, p));
      wait_ack(ch, 1'b1, "send_ack_hi");
      av[ch] = 1'b0;
      wait_ack(ch, 1'b0, "send_ack_lo");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      reset = 1'b1;
      tick(2);
      check("rst_valid", sv, 0);
      check("rst_data", sd, 0);
      check("rst_chan", sch, 0);
      check("rst_ack", ack, 0);

      // Single channel latency
      do_reset();
      sr = 1'b1;
      ad[1*BW +: BW] = 8'hA5;
      av[1] = 1'b1;
      sb.push_back(mk(1, 8'hA5, 1'b0));
      tick(2);
      check("t1_ack_e2", ack[1], 0);
      tick(1);
      check("t1_ack_e3", ack[1], 1);
      check("t1_valid_e3", sv, 0);
      tick(1);
      check("t1_valid_e4", sv, 1);
      check("t1_data_e4", sd, 8'hA5);
      check("t1_chan_e4", sch, 1);
      av[1] = 1'b0;
      tick(1);
      check("t1_valid_drop", sv, 0);
      n = 1;
      while (ack[1] !== 1'b0 && n < 20) begin
         tick(1);
         n++;
      end
      check("t1_ack_fall_edges", (n >= 2 && n <= 3), 1);

      // All channels at once, round-robin from channel 0
      do_reset();
      sr = 1'b1;
      for (int c = 0; c < CC; c++) begin
         ad[c*BW +: BW] = BW'(8'h10 + c);
         sb.push_back(mk(c, BW'(8'h10 + c), 1'b0));
      end
      av = '1;
      tick(3);
      check("t2_valid_e3", sv, 0);
      for (int c = 0; c < CC; c++) begin
         tick(1);
         check("t2_valid_seq", sv, 1);
         check("t2_chan_seq", sch, c);
      end
      av = '0;
      n = 0;
      while (ack !== '0 && n < 40) begin
         tick(1);
         n++;
      end
      check("t2_acks_low", ack, 0);

      // Back-pressure
      do_reset();
      sr = 1'b0;
      ad[2*BW +: BW] = 8'h3C;
      av[2] = 1'b1;
      sb.push_back(mk(2, 8'h3C, 1'b0));
      tick(4);
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_out", {sv, sch, sd}, {1'b1, 2'd2, 8'h3C});
         check("t3_hold_ack", ack[2], 1);
         tick(1);
      end
      sr = 1'b1;
      tick(1);
      check("t3_release", sv, 0);
      av[2] = 1'b0;
      wait_ack(2, 1'b0, "t3_ack_lo");

      // Fairness: ch3 beats ch0's second word on a tie
      do_reset();
      sr = 1'b1;
      send(0, 8'h40, 1'b0, 1'b1);
      sb.push_back(mk(3, 8'h70, 1'b0));
      sb.push_back(mk(0, 8'h41, 1'b0));
      fork
         send(0, 8'h41, 1'b0, 1'b0);
         send(3, 8'h70, 1'b0, 1'b0);
      join
      tick(2);
      check("t4_sb_drained", sb.size(), 0);

      // Mid-operation reset
      do_reset();
      sr = 1'b1;
      ad[1*BW +: BW] = 8'h5A;
      av[1] = 1'b1;
      sb.push_back(mk(1, 8'h5A, 1'b0));
      tick(3);
      check("t5_pending_ack", ack[1], 1);
      reset = 1'b1;
      sb.delete();
      tick(1);
      check("t5_rst_valid", sv, 0);
      check("t5_rst_ack", ack[1], 0);
      reset = 1'b0;
      sb.push_back(mk(1, 8'h5A, 1'b0));
      tick(3);
      check("t5_valid_e3", sv, 0);
      tick(1);
      check("t5_valid_e4", sv, 1);
      check("t5_data_e4", sd, 8'h5A);
      av[1] = 1'b0;
      wait_ack(1, 1'b0, "t5_ack_lo");

`ifdef MULTI_CHANNEL_DATA_SYNC_PARITY_EN
      do_reset();
      sr = 1'b1;
      send(0, 8'h07, 1'b0, 1'b1);
      send(0, 8'h07, 1'b1, 1'b1);
`endif

      tick(5);
      check("end_sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
